// File: rtl/arbiter_rr_4x12b_if.sv
// Upstream FIFO drain / downstream FIFO push bundle for arbiter_rr_4x12b.
// master = arbiter side (drives pops and pushes), slave = FIFO side.
interface arbiter_rr_4x12b_if #(
  parameter int DATA_W    = 12,
  parameter int NUM_LANES = 4
);
  logic [NUM_LANES-1:0] fifo_empty;
  logic [DATA_W-1:0]    fifo_data0;
  logic [DATA_W-1:0]    fifo_data1;
  logic [DATA_W-1:0]    fifo_data2;
  logic [DATA_W-1:0]    fifo_data3;
  logic [NUM_LANES-1:0] fifo_pop;
  logic [NUM_LANES-1:0] dest_almost_full;
  logic [NUM_LANES-1:0] push_out;
  logic [DATA_W-1:0]    data_out;

  modport master (
    input  fifo_empty, fifo_data0, fifo_data1, fifo_data2, fifo_data3,
    input  dest_almost_full,
    output fifo_pop, push_out, data_out
  );

  modport slave (
    output fifo_empty, fifo_data0, fifo_data1, fifo_data2, fifo_data3,
    output dest_almost_full,
    input  fifo_pop, push_out, data_out
  );
endinterface

// File: rtl/arbiter_rr_4x12b.sv
// Round-robin arbiter: drains four first-word-fall-through FIFOs, routes each
// word to the downstream FIFO named by its top two bits, one word per cycle,
// and counts words per destination.

// Per-requester eligibility: enabled, not empty, destination not almost full.
module arb_req_lane #(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = 2
) (
  input  logic                 en,
  input  logic                 empty,
  input  logic [LANE_W-1:0]    dest,
  input  logic [NUM_LANES-1:0] dest_af,
  output logic                 elig
);
  assign elig = en & ~empty & ~dest_af[dest];
endmodule

module arbiter_rr_4x12b #(
  parameter int DATA_W = 12,
  parameter int CNT_W  = 5
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic               enable,
  arbiter_rr_4x12b_if.master bus,
  output logic [CNT_W-1:0]   cnt0,
  output logic [CNT_W-1:0]   cnt1,
  output logic [CNT_W-1:0]   cnt2,
  output logic [CNT_W-1:0]   cnt3,
  output logic               idle
);
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 2;
  localparam int STAGES    = 1;
  localparam logic [NUM_LANES-1:0] ONE = {{(NUM_LANES-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic              vld;
    logic [LANE_W-1:0] idx;
  } grant_t;

  logic [NUM_LANES-1:0][DATA_W-1:0] head;
  logic [NUM_LANES-1:0][LANE_W-1:0] head_dest;
  logic [NUM_LANES-1:0]             elig;
  grant_t                           grant;

  logic [LANE_W-1:0]                ptr_q, ptr_d;
  logic [DATA_W-1:0]                data_q, data_d;
  logic [LANE_W-1:0]                dest_q, dest_d;
  logic [NUM_LANES-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  // Stage 0 is the combinational grant; stage 1 is the registered push.
  logic [STAGES:1]                  vld_pipe;

  assign head[0] = bus.fifo_data0;
  assign head[1] = bus.fifo_data1;
  assign head[2] = bus.fifo_data2;
  assign head[3] = bus.fifo_data3;

  // Reset gates eligibility so no pop escapes while reset_L is low.
  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      assign head_dest[i] = head[i][DATA_W-1 -: LANE_W];
      arb_req_lane #(.NUM_LANES(NUM_LANES), .LANE_W(LANE_W)) u_lane (
        .en      (enable & reset_L),
        .empty   (bus.fifo_empty[i]),
        .dest    (head_dest[i]),
        .dest_af (bus.dest_almost_full),
        .elig    (elig[i])
      );
    end
  endgenerate

  // Rotating priority search starting at ptr; first eligible index wins.
  always_comb begin
    logic [LANE_W-1:0] idx;
    idx   = '0;
    grant = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      idx = ptr_q + LANE_W'(k);
      if (!grant.vld && elig[idx]) begin
        grant.vld = 1'b1;
        grant.idx = idx;
      end
    end
  end

  assign bus.fifo_pop = grant.vld ? (ONE << grant.idx) : '0;

  // Next-state: latch granted word, advance ptr past the winner, bump counter.
  always_comb begin
    ptr_d  = ptr_q;
    data_d = data_q;
    dest_d = dest_q;
    cnt_d  = cnt_q;
    if (grant.vld) begin
      ptr_d  = grant.idx + LANE_W'(1);
      data_d = head[grant.idx];
      dest_d = head_dest[grant.idx];
      cnt_d[head_dest[grant.idx]] = cnt_q[head_dest[grant.idx]] + CNT_W'(1);
    end
  end

  // State registers; async reset aborts any in-flight word immediately.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      ptr_q    <= '0;
      data_q   <= '0;
      dest_q   <= '0;
      cnt_q    <= '0;
      vld_pipe <= '0;
    end else begin
      ptr_q    <= ptr_d;
      data_q   <= data_d;
      dest_q   <= dest_d;
      cnt_q    <= cnt_d;
      vld_pipe <= grant.vld;
    end
  end

  assign bus.push_out = vld_pipe[STAGES] ? (ONE << dest_q) : '0;
  assign bus.data_out = data_q;
  assign idle         = (&bus.fifo_empty) & ~vld_pipe[STAGES];

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
  assign cnt3 = cnt_q[3];
endmodule

// File: tb/tb_arbiter_rr_4x12b.sv
// Bench for arbiter_rr_4x12b: upstream FIFOs are TB queues, and the expected
// grant is the eligible requester at the smallest circular distance from ptr.
module tb_arbiter_rr_4x12b;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_L, enable;
  logic [4:0] cnt0, cnt1, cnt2, cnt3;
  logic       idle;

  arbiter_rr_4x12b_if bus();

  arbiter_rr_4x12b dut (
    .clk     (clk),
    .reset_L (reset_L),
    .enable  (enable),
    .bus     (bus),
    .cnt0    (cnt0),
    .cnt1    (cnt1),
    .cnt2    (cnt2),
    .cnt3    (cnt3),
    .idle    (idle)
  );

  logic [11:0] fq[4][$];
  logic [3:0]  af;
  int          n_vec, n_err;

  int          m_ptr;
  int          m_cnt[4];
  logic [3:0]  m_push;
  logic [11:0] m_data;

  function automatic logic [11:0] head(int i);
    if (fq[i].size() == 0) return 12'h000;
    return fq[i][0];
  endfunction

  function automatic logic [3:0] onehot(int d);
    logic [3:0] r;
    r    = 4'b0000;
    r[d] = 1'b1;
    return r;
  endfunction

  function automatic int ref_grant();
    int best, bestd, d;
    logic [11:0] h;
    best  = -1;
    bestd = 4;
    if (reset_L !== 1'b1 || enable !== 1'b1) return -1;
    for (int i = 0; i < 4; i++) begin
      h = head(i);
      d = (i - m_ptr + 4) % 4;
      if (fq[i].size() != 0 && !af[h[11:10]] && d < bestd) begin
        best  = i;
        bestd = d;
      end
    end
    return best;
  endfunction

  function automatic logic [3:0] exp_pop();
    int g;
    g = ref_grant();
    return (g < 0) ? 4'b0000 : onehot(g);
  endfunction

  function automatic logic [19:0] exp_cnt();
    return {5'(m_cnt[3]), 5'(m_cnt[2]), 5'(m_cnt[1]), 5'(m_cnt[0])};
  endfunction

  task automatic drive();
    for (int i = 0; i < 4; i++) bus.fifo_empty[i] = (fq[i].size() == 0);
    bus.fifo_data0       = head(0);
    bus.fifo_data1       = head(1);
    bus.fifo_data2       = head(2);
    bus.fifo_data3       = head(3);
    bus.dest_almost_full = af;
    #1;
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_push = 4'b0000;
    m_data = 12'h000;
  endtask

  // Advance one clock: the model consumes the grant seen before the edge.
  task automatic tick();
    int g;
    logic [11:0] h;
    g = ref_grant();
    @(posedge clk);
    if (g >= 0) begin
      h = fq[g].pop_front();
      m_push = onehot(int'(h[11:10]));
      m_data = h;
      m_cnt[h[11:10]] = (m_cnt[h[11:10]] + 1) % 32;
      m_ptr = (g + 1) % 4;
    end else begin
      m_push = 4'b0000;
    end
    @(negedge clk);
    drive();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_L = 1'b0;
    enable  = 1'b1;
    af      = 4'b0000;
    for (int i = 0; i < 4; i++) fq[i].delete();
    drive();
    model_reset();
    @(negedge clk);
    reset_L = 1'b1;
    drive();
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_L = 1'b0;
    enable  = 1'b1;
    af      = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      fq[i].delete();
      fq[i].push_back(12'($urandom));
    end
    drive();
    model_reset();
    n_vec++; if (bus.fifo_pop !== 4'b0000) begin n_err++; $display("FAIL reset_pop: got %b want 0000", bus.fifo_pop); end
    n_vec++; if (bus.push_out !== 4'b0000) begin n_err++; $display("FAIL reset_push: got %b want 0000", bus.push_out); end
    n_vec++; if (bus.data_out !== 12'h000) begin n_err++; $display("FAIL reset_data: got %h want 000", bus.data_out); end
    n_vec++; if ({cnt3, cnt2, cnt1, cnt0} !== 20'h0) begin n_err++; $display("FAIL reset_cnt: got %h want 00000", {cnt3, cnt2, cnt1, cnt0}); end
    n_vec++; if (idle !== 1'b0) begin n_err++; $display("FAIL reset_idle: got %b want 0", idle); end
    @(negedge clk);
    reset_L = 1'b1;
    drive();
    n_vec++; if (bus.fifo_pop !== 4'b0001) begin n_err++; $display("FAIL reset_first_grant: got %b want 0001", bus.fifo_pop); end
    tick();
    n_vec++; if (bus.push_out !== m_push || bus.data_out !== m_data) begin n_err++; $display("FAIL reset_first_push: got %b/%h want %b/%h", bus.push_out, bus.data_out, m_push, m_data); end
  endtask

  task automatic test_fairness();
    apply_reset();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 3; j++) fq[i].push_back({2'b00, 10'($urandom)});
    drive();
    for (int k = 0; k <= 12; k++) begin
      if (k < 12) begin
        n_vec++; if (bus.fifo_pop !== onehot(k % 4)) begin n_err++; $display("FAIL fair_pop[%0d]: got %b want %b", k, bus.fifo_pop, onehot(k % 4)); end
      end
      if (k > 0) begin
        n_vec++; if (bus.push_out !== 4'b0001 || bus.data_out !== m_data) begin n_err++; $display("FAIL fair_push[%0d]: got %b/%h want 0001/%h", k, bus.push_out, bus.data_out, m_data); end
      end
      tick();
    end
    n_vec++; if (bus.push_out !== 4'b0000) begin n_err++; $display("FAIL fair_push_end: got %b want 0000", bus.push_out); end
    n_vec++; if (cnt0 !== 5'd12) begin n_err++; $display("FAIL fair_cnt0: got %0d want 12", cnt0); end
  endtask

  task automatic test_routing();
    apply_reset();
    fq[2].push_back(12'hC05);
    drive();
    n_vec++; if (bus.fifo_pop !== 4'b0100) begin n_err++; $display("FAIL route_pop: got %b want 0100", bus.fifo_pop); end
    tick();
    n_vec++; if (bus.push_out !== 4'b1000 || bus.data_out !== 12'hC05) begin n_err++; $display("FAIL route_push: got %b/%h want 1000/c05", bus.push_out, bus.data_out); end
    n_vec++; if (cnt3 !== 5'd1) begin n_err++; $display("FAIL route_cnt3: got %0d want 1", cnt3); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    fq[0].push_back({2'b01, 10'($urandom)});
    fq[1].push_back({2'b10, 10'($urandom)});
    af = 4'b0010;
    drive();
    n_vec++; if (bus.fifo_pop !== 4'b0010) begin n_err++; $display("FAIL bp_skip: got %b want 0010", bus.fifo_pop); end
    tick();
    n_vec++; if (bus.push_out !== 4'b0100 || bus.data_out !== m_data) begin n_err++; $display("FAIL bp_push1: got %b/%h want 0100/%h", bus.push_out, bus.data_out, m_data); end
    n_vec++; if (bus.fifo_pop !== 4'b0000) begin n_err++; $display("FAIL bp_blocked: got %b want 0000", bus.fifo_pop); end
    af = 4'b0000;
    drive();
    n_vec++; if (bus.fifo_pop !== 4'b0001) begin n_err++; $display("FAIL bp_release: got %b want 0001", bus.fifo_pop); end
    tick();
    n_vec++; if (bus.push_out !== 4'b0010 || bus.data_out !== m_data) begin n_err++; $display("FAIL bp_push0: got %b/%h want 0010/%h", bus.push_out, bus.data_out, m_data); end
  endtask

  task automatic test_enable_idle();
    int cyc;
    apply_reset();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 2; j++) fq[i].push_back(12'($urandom));
    drive();
    tick();
    enable = 1'b0;
    drive();
    n_vec++; if (bus.fifo_pop !== 4'b0000) begin n_err++; $display("FAIL en_nopop: got %b want 0000", bus.fifo_pop); end
    n_vec++; if (bus.push_out !== m_push || m_push === 4'b0000) begin n_err++; $display("FAIL en_inflight: got %b want %b", bus.push_out, m_push); end
    tick();
    n_vec++; if (bus.push_out !== 4'b0000) begin n_err++; $display("FAIL en_push_off: got %b want 0000", bus.push_out); end
    n_vec++; if (idle !== 1'b0) begin n_err++; $display("FAIL en_idle_busy: got %b want 0", idle); end
    enable = 1'b1;
    drive();
    cyc = 0;
    while ((fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size()) != 0 && cyc < 40) begin
      n_vec++; if (bus.fifo_pop !== exp_pop()) begin n_err++; $display("FAIL drain_pop: got %b want %b", bus.fifo_pop, exp_pop()); end
      tick();
      cyc++;
    end
    n_vec++; if (cyc >= 40) begin n_err++; $display("FAIL drain_timeout: got %0d cycles want <40", cyc); end
    n_vec++; if (idle !== 1'b0) begin n_err++; $display("FAIL drain_idle_last: got %b want 0", idle); end
    tick();
    n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL drain_idle: got %b want 1", idle); end
  endtask

  task automatic test_wrap_reset();
    int loaded, pushed, cyc;
    apply_reset();
    loaded = 0;
    pushed = 0;
    cyc    = 0;
    while (pushed < 33 && cyc < 100) begin
      for (int i = 0; i < 4; i++)
        if (loaded < 33 && fq[i].size() < 8) begin
          fq[i].push_back({2'b00, 10'($urandom)});
          loaded++;
        end
      drive();
      tick();
      if (m_push !== 4'b0000) pushed++;
      cyc++;
    end
    n_vec++; if (cyc >= 100) begin n_err++; $display("FAIL wrap_timeout: got %0d pushes want 33", pushed); end
    n_vec++; if (cnt0 !== 5'd1 || m_cnt[0] != 1) begin n_err++; $display("FAIL wrap_cnt0: got %0d want 1", cnt0); end
    n_vec++; if (bus.push_out !== 4'b0001) begin n_err++; $display("FAIL wrap_push: got %b want 0001", bus.push_out); end
    #1;
    reset_L = 1'b0;
    #1;
    model_reset();
    n_vec++; if (bus.push_out !== 4'b0000 || bus.data_out !== 12'h000) begin n_err++; $display("FAIL async_reset: got %b/%h want 0000/000", bus.push_out, bus.data_out); end
    n_vec++; if ({cnt3, cnt2, cnt1, cnt0} !== 20'h0) begin n_err++; $display("FAIL async_reset_cnt: got %h want 00000", {cnt3, cnt2, cnt1, cnt0}); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 300; c++) begin
      n_vec++; if (bus.push_out !== m_push || bus.data_out !== m_data) begin n_err++; $display("FAIL rnd_push[%0d]: got %b/%h want %b/%h", c, bus.push_out, bus.data_out, m_push, m_data); end
      n_vec++; if ({cnt3, cnt2, cnt1, cnt0} !== exp_cnt()) begin n_err++; $display("FAIL rnd_cnt[%0d]: got %h want %h", c, {cnt3, cnt2, cnt1, cnt0}, exp_cnt()); end
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 2) == 0 && fq[i].size() < 8) fq[i].push_back(12'($urandom));
      af     = 4'($urandom & $urandom);
      enable = ($urandom_range(0, 9) != 0);
      drive();
      n_vec++; if (bus.fifo_pop !== exp_pop()) begin n_err++; $display("FAIL rnd_pop[%0d]: got %b want %b", c, bus.fifo_pop, exp_pop()); end
      n_vec++; if (idle !== (bus.fifo_empty == 4'hF && m_push == 4'b0000)) begin n_err++; $display("FAIL rnd_idle[%0d]: got %b", c, idle); end
      tick();
    end
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    reset_L = 1'b0;
    enable  = 1'b0;
    af      = 4'b0000;
    model_reset();
    drive();
    test_reset();
    test_fairness();
    test_routing();
    test_backpressure();
    test_enable_idle();
    test_wrap_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/arbiter_rr_4x12b.md
# arbiter_rr_4x12b

Round-robin arbiter that drains four upstream 8x12b FIFOs and routes each 12-bit word to one of four downstream FIFOs selected by its destination field. It sits directly downstream of the 8x12b FIFO stage: it consumes the FIFOs' `empty` and head-of-queue data and drives their `pop`. It honours the downstream FIFOs' `almost_full` as back-pressure. It also keeps per-destination word counters for the bench to check.

## Interface
- `DATA_W`, 12, word width; destination field is bits `[DATA_W-1:DATA_W-2]`.
- `CNT_W`, 5, width of each per-destination word counter.
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset_L`  in  1  asynchronous, active-low reset.
- `enable`  in  1  1 = arbitrate; 0 = issue no new pops. An in-flight push still completes.
- `fifo_empty`  in  4  `empty` of upstream FIFO i (bit i).
- `fifo_data0..fifo_data3`  in  12 each  head word of upstream FIFO i. First-word fall-through: the head word is valid whenever `fifo_empty[i]`=0.
- `fifo_pop`  out  4  one-hot or zero; combinational pop to upstream FIFO i.
- `dest_almost_full`  in  4  `almost_full` of downstream FIFO d.
- `push_out`  out  4  one-hot or zero, registered; push to downstream FIFO d.
- `data_out`  out  12  registered word accompanying `push_out`.
- `cnt0..cnt3`  out  `CNT_W` each  count of words pushed to destination d.
- `idle`  out  1  1 when `fifo_empty`=4'b1111 and `push_out`=0.

## Operation
- Eligibility: requester i is eligible when all of these hold:
  - `enable`=1
  - `reset_L`=1
  - `fifo_empty[i]`=0
  - `dest_almost_full[fifo_dataI[11:10]]`=0
- Grant: search i = ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first eligible requester wins. `fifo_pop[g]`=1 in the same cycle, combinationally. At most one grant per cycle.
- On the clock edge with grant g:
  - `data_out` <= `fifo_dataG`
  - `push_out` <= one-hot(`fifo_dataG[11:10]`)
  - `ptr` <= (g+1) mod 4
  - the counter of that destination increments.
- No grant: `push_out` <= 0, `data_out` holds its last value, `ptr` holds.
- Counters wrap modulo 2^`CNT_W` (31 -> 0) with no flag.
- Back-pressure: the arbiter does not track in-flight words. Downstream `almost_full` thresholds (`umbral_superior`) must leave at least 2 free slots so that neither the word currently in flight nor the next granted word is lost.
- A blocked requester (destination almost full) is skipped and does not stall the others. It keeps its place: `ptr` only moves past a granted index.
- Reset values: `ptr`=0, `push_out`=0, `data_out`=0, `cnt0..3`=0, `idle`=1 if all FIFOs are empty. While `reset_L`=0, `fifo_pop`=0.

## Timing
- Latency: pop in cycle N produces `push_out`/`data_out` valid in cycle N+1, for exactly one cycle per word.
- Throughput: one word per cycle when eligible requesters exist.
- `enable` falling: no pop in that same cycle. A push registered at the prior edge still appears.
- `dest_almost_full` is sampled combinationally in the grant cycle. The arbiter adds no extra delay.
- Simultaneous events:
  - `fifo_empty[i]` rising and `fifo_pop[i]` in the same cycle is impossible, because pop requires `empty`=0.
  - When all four requesters are eligible, grants rotate 0,1,2,3,0,... starting from `ptr`.
- Reset mid-operation: asserting `reset_L` clears `push_out` and `data_out` immediately (asynchronous) and aborts the in-flight word. Upstream FIFO contents are not re-pushed.

## Test plan
- Reset: `reset_L`=0 with all FIFOs non-empty -> `fifo_pop`=0, `push_out`=0, `data_out`=12'h000, counters 0. Release reset -> first grant goes to FIFO0.
- Fairness: all four FIFOs hold 3 words addressed to dest 0, `dest_almost_full`=0 -> pop order 0,1,2,3,0,1,2,3,0,1,2,3. `push_out`=4'b0001 for 12 consecutive cycles, each one cycle after its pop. `cnt0`=12.
- Routing: FIFO2 head 12'hC05 -> one cycle after the pop, `push_out`=4'b1000 and `data_out`=12'hC05. `cnt3` increments by 1.
- Back-pressure skip: FIFO0 head to dest 1 with `dest_almost_full[1]`=1, FIFO1 head to dest 2 -> FIFO1 is granted and FIFO0 is not popped. Drop `dest_almost_full[1]` -> FIFO0 is granted next.
- Enable and idle: `enable`=0 while words remain -> no pops, `push_out`=0 after one cycle. Drain all FIFOs with `enable`=1 -> `idle`=1 the cycle after the last push.
- Counter wrap and mid-run reset: push 33 words to dest 0 -> `cnt0`=1. Assert `reset_L`=0 during a push -> `push_out` drops to 0 without waiting for a clock edge.
